// File: rtl/fpu_add_issue_if.sv
// Request, adder-side and response signals of the fpu_add_issue stage.
interface fpu_add_issue_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic             req_sub;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      add_src_a;
  logic [31:0]      add_src_b;
  logic             add_subtract;
  logic [31:0]      add_dest;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_tag, add_dest, rsp_ready,
    output req_ready, add_src_a, add_src_b, add_subtract, rsp_valid, rsp_result, rsp_tag
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, req_tag, add_dest, rsp_ready,
    input  req_ready, add_src_a, add_src_b, add_subtract, rsp_valid, rsp_result, rsp_tag
  );
endinterface

// File: rtl/fpu_add_issue.sv
// Issue/retire wrapper for the 1-cycle registered FP adder: 3-cycle accept-to-response, credit-limited to DEPTH ops.
// Zero/denormal operands bypass the adder; FPU_ADD_SPECIALS_EN also bypasses inf/NaN operands.
module fpu_add_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  fpu_add_issue_if.slave io
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]    cnt_q, cnt_d, occ_q, occ_d;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [31:0]      res_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic             s1_valid_q, s1_byp_q, s2_valid_q, s2_byp_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  logic [31:0]      s1_bval_q, s2_bval_q;
  logic [31:0]      src_a_q, src_b_q;
  logic             sub_q;

  logic        accept, pop, push;
  logic        a_zero, b_zero, byp_d;
  logic [31:0] b_adj, bval_d, wr_dat;

  assign io.req_ready    = (cnt_q < DEPTH_C);
  assign accept          = io.req_valid & io.req_ready;
  assign io.rsp_valid    = (occ_q != '0);
  assign pop             = io.rsp_valid & io.rsp_ready;
  assign push            = s2_valid_q;
  assign io.rsp_result   = res_mem_q[rd_ptr_q];
  assign io.rsp_tag      = tag_mem_q[rd_ptr_q];
  assign io.add_src_a    = src_a_q;
  assign io.add_src_b    = src_b_q;
  assign io.add_subtract = sub_q;
  assign wr_dat          = s2_byp_q ? s2_bval_q : io.add_dest;

  assign a_zero = (io.req_a[30:23] == 8'h00);
  assign b_zero = (io.req_b[30:23] == 8'h00);
  assign b_adj  = {io.req_b[31] ^ io.req_sub, io.req_b[30:0]};

`ifdef FPU_ADD_SPECIALS_EN
  logic a_max, b_max, a_nan, b_nan, a_inf, b_inf;
  assign a_max = (io.req_a[30:23] == 8'hFF);
  assign b_max = (io.req_b[30:23] == 8'hFF);
  assign a_nan = a_max & (io.req_a[22:0] != '0);
  assign b_nan = b_max & (io.req_b[22:0] != '0);
  assign a_inf = a_max & (io.req_a[22:0] == '0);
  assign b_inf = b_max & (io.req_b[22:0] == '0);
`endif

  // Bypass value is resolved at accept so the adder result is never needed for these ops.
  always_comb begin
    byp_d  = 1'b1;
    bval_d = '0;
    if (a_zero && b_zero) bval_d = '0;
    else if (a_zero)      bval_d = b_adj;
    else if (b_zero)      bval_d = io.req_a;
    else                  byp_d  = 1'b0;
`ifdef FPU_ADD_SPECIALS_EN
    if (a_nan || b_nan || (a_inf && b_inf && (io.req_a[31] != b_adj[31]))) begin
      byp_d  = 1'b1;
      bval_d = 32'h7FC0_0000;
    end else if (a_inf) begin
      byp_d  = 1'b1;
      bval_d = io.req_a;
    end else if (b_inf) begin
      byp_d  = 1'b1;
      bval_d = b_adj;
    end
`endif
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!accept && pop) cnt_d = cnt_q - CW'(1);
    occ_d = occ_q;
    if (push && !pop)        occ_d = occ_q + CW'(1);
    else if (!push && pop)   occ_d = occ_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_byp_q   <= 1'b0;
      s1_tag_q   <= '0;
      s1_bval_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_byp_q   <= 1'b0;
      s2_tag_q   <= '0;
      s2_bval_q  <= '0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      sub_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        res_mem_q[i] <= '0;
        tag_mem_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      occ_q      <= occ_d;
      s1_valid_q <= accept;
      if (accept) begin
        src_a_q   <= io.req_a;
        src_b_q   <= io.req_b;
        sub_q     <= io.req_sub;
        s1_tag_q  <= io.req_tag;
        s1_byp_q  <= byp_d;
        s1_bval_q <= bval_d;
      end
      s2_valid_q <= s1_valid_q;
      s2_byp_q   <= s1_byp_q;
      s2_tag_q   <= s1_tag_q;
      s2_bval_q  <= s1_bval_q;
      if (push) begin
        res_mem_q[wr_ptr_q] <= wr_dat;
        tag_mem_q[wr_ptr_q] <= s2_tag_q;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Credits reserve a slot for every in-flight op, so the adder never overruns the FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (occ_q == DEPTH_C)));
endmodule

// File: tb/tb_fpu_add_issue.sv
// Directed bench for fpu_add_issue with a spec-level result model and per-cycle response checking.
module tb_fpu_add_issue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_add_issue_if #(.TAG_W(TAG_W)) ifc ();
  fpu_add_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .io(ifc.slave));

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t             q[$];
  logic [31:0]      got_res[$];
  logic [TAG_W-1:0] got_tag[$];
  int               got_cyc[$];
  int               got_lat[$];
  int checks = 0, errors = 0, cyc = 0, n_acc = 0;
  logic             held_vld = 1'b0;
  logic [31:0]      held_res;
  logic [TAG_W-1:0] held_tag;

  // Adder stand-in: always inserts the hidden bit, like the real unit, so a missed bypass shows.
  function automatic real to_real(input logic [31:0] x);
    real m;
    int  e;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] from_real(input real v);
    logic        s;
    int          e;
    real         r;
    logic [31:0] mb;
    logic [7:0]  eb;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    r = s ? -v : v;
    e = 127;
    while (r >= 2.0) begin r = r / 2.0; e++; end
    while (r < 1.0)  begin r = r * 2.0; e--; end
    if (e <= 0)   return {s, 31'h0};
    if (e >= 255) return {s, 8'hFF, 23'h0};
    mb = 32'($rtoi((r - 1.0) * 8388608.0));
    eb = 8'(e);
    return {s, eb, mb[22:0]};
  endfunction

  function automatic logic [31:0] adder_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    return from_real(sub ? (to_real(a) - to_real(b)) : (to_real(a) + to_real(b)));
  endfunction

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] bb;
    bb = {b[31] ^ sub, b[30:0]};
`ifdef FPU_ADD_SPECIALS_EN
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (bb[30:23] == 8'hFF && bb[22:0] != 0)) return 32'h7FC00000;
    if (a[30:23] == 8'hFF && bb[30:23] == 8'hFF) return (a[31] == bb[31]) ? a : 32'h7FC00000;
    if (a[30:23] == 8'hFF)  return a;
    if (bb[30:23] == 8'hFF) return bb;
`endif
    if (a[30:23] == 0 && bb[30:23] == 0) return 32'h0;
    if (a[30:23] == 0)  return bb;
    if (bb[30:23] == 0) return a;
    return adder_model(a, b, sub);
  endfunction

  always @(posedge clk) ifc.add_dest <= adder_model(ifc.add_src_a, ifc.add_src_b, ifc.add_subtract);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t hd;
    if (!rst_n) begin
      chk("rst_rsp_valid", 32'(ifc.rsp_valid), 0);
      chk("rst_src_a", ifc.add_src_a, 0);
      held_vld = 1'b0;
      return;
    end
    chk("rsp_valid", 32'(ifc.rsp_valid), 32'(q.size() > 0 && (q[0].acc + 3 <= cyc)));
    chk("req_ready", 32'(ifc.req_ready), 32'(q.size() < DEPTH));
    if (held_vld && ifc.rsp_valid) begin
      chk("hold_result", ifc.rsp_result, held_res);
      chk("hold_tag", 32'(ifc.rsp_tag), 32'(held_tag));
    end
    if (ifc.rsp_valid && ifc.rsp_ready && q.size() > 0) begin
      hd = q.pop_front();
      chk("rsp_result", ifc.rsp_result, hd.res);
      chk("rsp_tag", 32'(ifc.rsp_tag), 32'(hd.tag));
      got_res.push_back(ifc.rsp_result);
      got_tag.push_back(ifc.rsp_tag);
      got_cyc.push_back(cyc);
      got_lat.push_back(cyc - hd.acc);
    end
    held_vld = ifc.rsp_valid && !ifc.rsp_ready;
    held_res = ifc.rsp_result;
    held_tag = ifc.rsp_tag;
    if (ifc.req_valid && ifc.req_ready) begin
      hd.res = ref_op(ifc.req_a, ifc.req_b, ifc.req_sub);
      hd.tag = ifc.req_tag;
      hd.acc = cyc;
      q.push_back(hd);
      n_acc++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [TAG_W-1:0] tag);
    ifc.req_valid = 1'b1;
    ifc.req_a     = a;
    ifc.req_b     = b;
    ifc.req_sub   = sub;
    ifc.req_tag   = tag;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [TAG_W-1:0] tag);
    int start;
    int t;
    start = n_acc;
    t = 0;
    set_req(a, b, sub, tag);
    while (n_acc == start && t < 50) begin step(); t++; end
    if (n_acc == start) chk("issue_timeout", 0, 1);
    ifc.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() > 0 && t < 200) begin step(); t++; end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int base, start, first_cyc;
    ifc.req_valid = 1'b0;
    ifc.req_a     = '0;
    ifc.req_b     = '0;
    ifc.req_sub   = 1'b0;
    ifc.req_tag   = '0;
    ifc.rsp_ready = 1'b0;
    ifc.add_dest  = '0;

    repeat (3) step();
    chk("rst_rsp_result", ifc.rsp_result, 0);
    chk("rst_rsp_tag", 32'(ifc.rsp_tag), 0);
    chk("rst_src_b", ifc.add_src_b, 0);
    chk("rst_subtract", 32'(ifc.add_subtract), 0);
    rst_n = 1'b1;
    chk("ready_after_release", 32'(ifc.req_ready), 1);
    chk("model_pin_add", ref_op(32'h3F800000, 32'h40000000, 1'b0), 32'h40400000);

    // Basic add with exact 3-cycle latency.
    ifc.rsp_ready = 1'b1;
    base = got_res.size();
    issue(32'h3F800000, 32'h40000000, 1'b0, 4'd5);
    drain();
    chk("basic_result", got_res[base], 32'h40400000);
    chk("basic_tag", 32'(got_tag[base]), 5);
    chk("basic_latency", got_lat[base], 3);

    // Zero and denormal operands.
    base = got_res.size();
    issue(32'h00000000, 32'h40000000, 1'b1, 4'd1);
    issue(32'h40490FDB, 32'h00000000, 1'b0, 4'd2);
    issue(32'h00000000, 32'h00000000, 1'b0, 4'd3);
    issue(32'h00400000, 32'h00800000, 1'b0, 4'd4);
    issue(32'h80000001, 32'h00000005, 1'b1, 4'd6);
    drain();
    chk("zero_a_sub", got_res[base], 32'hC0000000);
    chk("zero_b", got_res[base+1], 32'h40490FDB);
    chk("zero_both", got_res[base+2], 32'h00000000);
    chk("denorm_a", got_res[base+3], 32'h00800000);
    chk("denorm_both", got_res[base+4], 32'h00000000);

    // Back-pressure: six ops against a stalled consumer.
    ifc.rsp_ready = 1'b0;
    base = got_res.size();
    start = n_acc;
    repeat (10) begin
      set_req(32'h3F800000, 32'h40000000, 1'b0, 4'(n_acc - start));
      step();
    end
    chk("bp_accepts", n_acc - start, 4);
    chk("bp_req_ready", 32'(ifc.req_ready), 0);
    ifc.rsp_ready = 1'b1;
    for (int t = 0; t < 40 && (n_acc - start) < 6; t++) begin
      set_req(32'h3F800000, 32'h40000000, 1'b0, 4'(n_acc - start));
      step();
    end
    ifc.req_valid = 1'b0;
    drain();
    chk("bp_count", got_res.size() - base, 6);
    for (int i = 0; i < 6; i++) chk("bp_order", 32'(got_tag[base+i]), i);

    // Streaming: 16 back-to-back ops, one response per cycle.
    base = got_res.size();
    start = n_acc;
    first_cyc = cyc;
    for (int i = 0; i < 16; i++) begin
      set_req(32'h40000000 | (i << 18), 32'h3F800000 | (i << 20), i[0], 4'(i));
      step();
    end
    ifc.req_valid = 1'b0;
    chk("stream_accepts", n_acc - start, 16);
    drain();
    for (int i = 0; i < 16; i++) chk("stream_cycle", got_cyc[base+i], first_cyc + 3 + i);

    // Reset with ops in flight and buffered.
    ifc.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(32'h3F800000, 32'h3F800000, 1'b0, 4'(8 + i));
      step();
    end
    ifc.req_valid = 1'b0;
    repeat (2) step();
    chk("pre_reset_valid", 32'(ifc.rsp_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(ifc.rsp_valid), 0);
    q.delete();
    held_vld = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    chk("post_reset_ready", 32'(ifc.req_ready), 1);
    ifc.rsp_ready = 1'b1;
    base = got_res.size();
    repeat (10) step();
    chk("no_stale_rsp", got_res.size() - base, 0);

`ifdef FPU_ADD_SPECIALS_EN
    base = got_res.size();
    issue(32'h7F800000, 32'hFF800000, 1'b0, 4'd1);
    issue(32'h7F800000, 32'h3F800000, 1'b1, 4'd2);
    drain();
    chk("inf_minus_inf", got_res[base], 32'h7FC00000);
    chk("inf_minus_one", got_res[base+1], 32'h7F800000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_add_issue.md
Name: fpu_add_issue

Overview:
- Issue/retire stage wrapped around the single-cycle registered IEEE-754 single-precision adder (`ieee754_add`).
- Accepts operand requests on a valid/ready interface and registers operands into the adder.
- Tracks each op through the adder's fixed 1-cycle latency and buffers results in a small FIFO with a ready/valid response port.
- Bypasses zero/denormal operands, which the adder mishandles because it always inserts the hidden bit.

Parameters:
- DEPTH, 4: response FIFO entries; also the maximum number of outstanding ops (credit limit). Power of two, ≥2.
- TAG_W, 4: width of the opaque request tag carried to the response.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_a  in  32  operand A, IEEE-754 single.
- req_b  in  32  operand B, IEEE-754 single.
- req_sub  in  1  1 = A−B, 0 = A+B.
- req_tag  in  TAG_W  returned unchanged with the result.
- add_src_a  out  32  to adder src_a, registered.
- add_src_b  out  32  to adder src_b, registered.
- add_subtract  out  1  to adder subtract, registered.
- add_dest  in  32  adder dest; valid the cycle after add_src_* are driven.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer pops head when rsp_valid & rsp_ready.
- rsp_result  out  32  result at FIFO head.
- rsp_tag  out  TAG_W  tag at FIFO head.

Behaviour:
- Reset (async assert, sync release): add_src_a/add_src_b/add_subtract = 0, rsp_valid = 0, rsp_result = 0, rsp_tag = 0. All stage valids cleared, FIFO pointers and credit count = 0. req_ready = 1 in the first cycle after release.
- Credits: `cnt` = ops in S1 + ops in S2 + FIFO occupancy, width clog2(DEPTH)+1.
  - req_ready = (cnt < DEPTH), derived combinationally from registers only; no path from req_valid or rsp_ready.
  - Increment on accept, decrement on pop; simultaneous accept and pop leaves cnt unchanged.
  - The adder has no stall, so credits guarantee every in-flight result has a FIFO slot.
- S1 (cycle T+1 after accept at T): add_src_* ← operands.
  - s1_valid, s1_tag and s1_byp/s1_bval are captured in the same cycle.
  - add_src_* hold their last values when no request is accepted.
- S2 (T+2): s2_* ← s1_*. Write the FIFO at the end of T+2 with data = s2_byp ? s2_bval : add_dest.
- Response: rsp_valid is asserted no earlier than T+3, so minimum latency is 3 cycles, accept to rsp_valid.
  - Order is strict FIFO.
  - rsp_result/rsp_tag stay stable while rsp_valid & !rsp_ready.
- Bypass (flush-to-zero), decided at accept. An operand with exponent == 0 is treated as zero. Let b' = req_b with sign inverted if req_sub.
  - A zero, B nonzero: bval = b'.
  - B zero, A nonzero: bval = req_a.
  - Both zero: bval = +0 (0x00000000).
  - Neither zero: no bypass; the adder result is used.
- FIFO pointers wrap modulo DEPTH.
- Full/empty is derived from occupancy, not from pointer equality alone.
- A write into a full FIFO is impossible by construction; assert in simulation.
- Reset asserted mid-operation discards all in-flight and buffered ops; no response is produced for them.

Optional Feature:
- Macro: FPU_ADD_SPECIALS_EN.
- Defined: exponent-255 operands are also bypassed.
  - Any NaN operand, or +inf plus −inf (after applying req_sub), → 0x7FC00000.
  - Otherwise a single inf operand → that inf (sign-adjusted for B).
  - Two same-sign infs → that inf.
  - Precedence: NaN/inf rules override the zero rules.
- Undefined: exponent-255 operands go through the adder unmodified. Zero bypass is unaffected.

Test Plan:
- Basic add: req_a=0x3F800000, req_b=0x40000000, sub=0, tag=5 → after 3 cycles rsp_result=0x40400000, rsp_tag=5.
- Zero bypass: a=0x00000000, b=0x40000000, sub=1 → 0xC0000000. a=0x40490FDB, b=0x00000000 → 0x40490FDB. Both zero → 0x00000000.
- Back-pressure: DEPTH=4, rsp_ready=0, req_valid held for 6 back-to-back ops (tags 0..5).
  - req_ready deasserts after 4 accepts.
  - Raising rsp_ready drains tags 0..3 in order, then accepts 4 and 5.
  - No loss or duplicate.
- Streaming: rsp_ready=1, 16 back-to-back ops → req_ready never drops and one response per cycle after the initial 3-cycle latency.
- Reset mid-flight: 3 ops outstanding, pulse rst_n low asynchronously → rsp_valid=0 immediately, req_ready=1 after release, no stale responses.
- With FPU_ADD_SPECIALS_EN: 0x7F800000 + 0xFF800000 → 0x7FC00000; 0x7F800000 − 0x3F800000 → 0x7F800000.
